// File: rtl/vp_pkg.sv
// Shared types, constants and fixed-point helpers for the viewport stage.
package vp_pkg;

    // Signed Q16.16 fixed-point value.
    typedef logic signed [31:0] q16_t;

    localparam q16_t ONE    = 32'sh0001_0000;
    localparam q16_t HALF   = 32'sh0000_8000;
    localparam q16_t HALF_W = 32'sh0140_0000;
    localparam q16_t HALF_H = 32'sh00F0_0000;

    // Last iteration index of the 33-step reciprocal divider.
    localparam logic [5:0] DIV_LAST = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        MAP,
        OUT
    } state_t;

    // Q16.16 multiply: full signed product, arithmetic shift by 16, low 32 bits kept (wraps).
    function automatic q16_t fmul(input q16_t a, input q16_t b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return q16_t'(p >>> 16);
    endfunction

endpackage

// File: rtl/recip_div.sv
// Sequential restoring divider computing floor(2^32 / d), one quotient bit per cycle, MSB first.
module recip_div
    import vp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] d,
    output logic        busy,
    output logic        done,
    output logic [32:0] q
);

    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic        busy_q, busy_d;
    logic [32:0] trial;

    // One restoring step per cycle; the dividend 2^32 contributes a single 1 on the first step.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        busy_d = busy_q;
        trial  = {rem_q, (cnt_q == 6'd0)};
        if (start) begin
            div_d  = d;
            rem_d  = '0;
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d = 32'(trial - {1'b0, div_q});
                quo_d = {quo_q[31:0], 1'b1};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[31:0], 1'b0};
            end
            if (cnt_q == DIV_LAST) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == DIV_LAST);
    assign q    = quo_q;

endmodule

// File: rtl/vertex_viewport.sv
// Perspective divide and viewport mapping of one triangle at a time into 640x480 screen space.
module vertex_viewport
    import vp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_in [3:0],
    input  logic [31:0] y_in [3:0],
    input  logic [31:0] z_in [3:0],
    input  logic [31:0] w_in [3:0],
    input  logic        in_valid,
    input  logic        done_in,
    input  logic        stall_in,
    output logic [31:0] sx_out [2:0],
    output logic [31:0] sy_out [2:0],
    output logic [31:0] sz_out [2:0],
    output logic [2:0]  clip_out,
    output logic        out_valid,
    output logic        done_out,
    output logic        stall_out
);

    state_t      state_q, state_d;
    logic [1:0]  v_q, v_d;
    logic        done_q, done_d;
    q16_t        x_q [2:0], x_d [2:0];
    q16_t        y_q [2:0], y_d [2:0];
    q16_t        z_q [2:0], z_d [2:0];
    q16_t        w_q [2:0], w_d [2:0];
    q16_t        sx_q [2:0], sx_d [2:0];
    q16_t        sy_q [2:0], sy_d [2:0];
    q16_t        sz_q [2:0], sz_d [2:0];
    logic [2:0]  clip_q, clip_d;

    logic        div_start, div_busy, div_done;
    logic [31:0] div_d;
    logic [32:0] div_q;
    logic        clip_v;
    q16_t        r, nx, ny, nz, nz_half, sx_v, sy_v, sz_v;
    logic        unused_bits;

    // Element 3 of each input and the quotient MSB (only set when w is clipped) are never consumed.
    assign unused_bits = ^{x_in[3], y_in[3], z_in[3], w_in[3], div_q[32], div_busy};

    recip_div u_div (
        .clock (clock),
        .reset (reset),
        .start (div_start),
        .d     (div_d),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: three divides with one map cycle each, then hold until the rasterizer takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = DIV;
            DIV:  if (div_done) state_d = MAP;
            MAP:  state_d = (v_q == 2'd2) ? OUT : DIV;
            OUT:  if (!stall_in) state_d = IDLE;
        endcase
    end

    // Moore outputs driven from the state and the result registers.
    always_comb begin
        out_valid = (state_q == OUT);
        done_out  = (state_q == OUT) && done_q;
        stall_out = (state_q != IDLE);
        clip_out  = clip_q;
        for (int i = 0; i < 3; i++) begin
            sx_out[i] = sx_q[i];
            sy_out[i] = sy_q[i];
            sz_out[i] = sz_q[i];
        end
    end

    // Divider launch and viewport arithmetic for the current vertex.
    always_comb begin
        div_start = ((state_q == IDLE) && in_valid) || ((state_q == MAP) && (v_q != 2'd2));
        div_d     = (state_q == IDLE) ? w_in[0] : ((v_q == 2'd0) ? w_q[1] : w_q[2]);
        clip_v    = (w_q[v_q] < ONE);
        r         = div_q[31:0];
        nx        = fmul(x_q[v_q], r);
        ny        = fmul(y_q[v_q], r);
        nz        = fmul(z_q[v_q], r);
        nz_half   = nz >>> 1;
        sx_v      = HALF_W + fmul(nx, HALF_W);
        sy_v      = HALF_H - fmul(ny, HALF_H);
        sz_v      = HALF + nz_half;
    end

    // Vertex latch on acceptance; result write-back at the current vertex index during MAP.
    always_comb begin
        v_d    = v_q;
        done_d = done_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        w_d    = w_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        sz_d   = sz_q;
        clip_d = clip_q;
        if ((state_q == IDLE) && in_valid) begin
            v_d    = 2'd0;
            done_d = done_in;
            for (int i = 0; i < 3; i++) begin
                x_d[i] = x_in[i];
                y_d[i] = y_in[i];
                z_d[i] = z_in[i];
                w_d[i] = w_in[i];
            end
        end
        if (state_q == MAP) begin
            sx_d[v_q]   = clip_v ? '0 : sx_v;
            sy_d[v_q]   = clip_v ? '0 : sy_v;
            sz_d[v_q]   = clip_v ? '0 : sz_v;
            clip_d[v_q] = clip_v;
            if (v_q != 2'd2) v_d = v_q + 2'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the small vertex/result arrays are real flops, so they take the async reset like any other state.
        if (!reset) begin
            v_q    <= '0;
            done_q <= 1'b0;
            clip_q <= '0;
            for (int i = 0; i < 3; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                z_q[i]  <= '0;
                w_q[i]  <= '0;
                sx_q[i] <= '0;
                sy_q[i] <= '0;
                sz_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            done_q <= done_d;
            clip_q <= clip_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            w_q    <= w_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            sz_q   <= sz_d;
        end
    end

endmodule

// File: tb/tb_vertex_viewport.sv
// Self-checking bench for vertex_viewport: directed table, stall/reset sequences, random vs. model.
module tb_vertex_viewport;

    typedef struct {
        logic [2:0][31:0] x, y, z, w;
        logic             done;
        logic [2:0][31:0] sx, sy, sz;
        logic [2:0]       clip;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [31:0] x_in [3:0];
    logic [31:0] y_in [3:0];
    logic [31:0] z_in [3:0];
    logic [31:0] w_in [3:0];
    logic        in_valid, done_in, stall_in;
    logic [31:0] sx_out [2:0];
    logic [31:0] sy_out [2:0];
    logic [31:0] sz_out [2:0];
    logic [2:0]  clip_out;
    logic        out_valid, done_out, stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    vertex_viewport dut (
        .clock     (clock),
        .reset     (reset),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .w_in      (w_in),
        .in_valid  (in_valid),
        .done_in   (done_in),
        .stall_in  (stall_in),
        .sx_out    (sx_out),
        .sy_out    (sy_out),
        .sz_out    (sz_out),
        .clip_out  (clip_out),
        .out_valid (out_valid),
        .done_out  (done_out),
        .stall_out (stall_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Q16.16 multiply from its arithmetic definition.
    function automatic logic [31:0] fx(input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint p;
        ia = a;
        ib = b;
        p  = longint'(ia) * longint'(ib);
        p  = p >>> 16;
        return p[31:0];
    endfunction

    // Reference: reciprocal by integer division, then the viewport formulas.
    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          wi, nzi, hz;
        longint      r;
        logic [31:0] nx, ny, nz;
        e = v;
        for (int i = 0; i < 3; i++) begin
            wi = v.w[i];
            if (wi < 65536) begin
                e.clip[i] = 1'b1;
                e.sx[i]   = '0;
                e.sy[i]   = '0;
                e.sz[i]   = '0;
            end else begin
                r  = 64'h1_0000_0000 / longint'(wi);
                nx = fx(v.x[i], r[31:0]);
                ny = fx(v.y[i], r[31:0]);
                nz = fx(v.z[i], r[31:0]);
                nzi = nz;
                hz  = nzi >>> 1;
                e.clip[i] = 1'b0;
                e.sx[i]   = 32'h0140_0000 + fx(nx, 32'h0140_0000);
                e.sy[i]   = 32'h00F0_0000 - fx(ny, 32'h00F0_0000);
                e.sz[i]   = 32'h0000_8000 + hz;
            end
        end
        return e;
    endfunction

    function automatic vec_t put(input vec_t v, input int i,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] w,
                                 input logic [31:0] sx, input logic [31:0] sy,
                                 input logic [31:0] sz, input logic c);
        vec_t o;
        o = v;
        o.x[i] = x;  o.y[i] = y;  o.z[i] = z;  o.w[i] = w;
        o.sx[i] = sx; o.sy[i] = sy; o.sz[i] = sz; o.clip[i] = c;
        return o;
    endfunction

    function automatic logic [31:0] rand_coord();
        if ($urandom_range(0, 1) == 0) return $urandom;
        return $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 3))
                0:       v.w[i] = $urandom_range(32'h0001_0000, 32'h0010_0000);
                1:       v.w[i] = $urandom;
                2:       v.w[i] = $urandom_range(0, 32'h0000_FFFF);
                default: v.w[i] = 32'h0001_0000 << $urandom_range(0, 6);
            endcase
            v.x[i] = rand_coord();
            v.y[i] = rand_coord();
            v.z[i] = rand_coord();
        end
        v.done = 1'($urandom_range(0, 1));
        return model(v);
    endfunction

    task automatic apply(input vec_t v);
        for (int i = 0; i < 3; i++) begin
            x_in[i] = v.x[i];
            y_in[i] = v.y[i];
            z_in[i] = v.z[i];
            w_in[i] = v.w[i];
        end
        x_in[3]  = $urandom;
        y_in[3]  = $urandom;
        z_in[3]  = $urandom;
        w_in[3]  = $urandom;
        done_in  = v.done;
        in_valid = 1'b1;
    endtask

    // After acceptance the inputs are garbage; the DUT must work from its latched copy.
    task automatic scramble();
        for (int i = 0; i < 4; i++) begin
            x_in[i] = $urandom;
            y_in[i] = $urandom;
            z_in[i] = $urandom;
            w_in[i] = $urandom;
        end
        done_in  = 1'($urandom_range(0, 1));
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid shows, bounded.
    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        check({tag, " latency"}, lat, 102);
    endtask

    task automatic compare_out(input string tag, input vec_t e);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s sx%0d", tag, i), sx_out[i], e.sx[i]);
            check($sformatf("%s sy%0d", tag, i), sy_out[i], e.sy[i]);
            check($sformatf("%s sz%0d", tag, i), sz_out[i], e.sz[i]);
        end
        check({tag, " clip"}, {29'b0, clip_out}, {29'b0, e.clip});
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, " done_out"}, {31'b0, done_out}, {31'b0, e.done});
        check({tag, " stall_out"}, {31'b0, stall_out}, 32'd1);
    endtask

    // Called with the DUT idle, #1 after a rising edge.
    task automatic run(input string tag, input vec_t v);
        apply(v);
        @(posedge clock);
        #1;
        scramble();
        check({tag, " stall rise"}, {31'b0, stall_out}, 32'd1);
        wait_out(tag);
        compare_out(tag, v);
        @(posedge clock);
        #1;
        check({tag, " release valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, " release done"}, {31'b0, done_out}, 32'd0);
        check({tag, " release stall"}, {31'b0, stall_out}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, " done_out"}, {31'b0, done_out}, 32'd0);
        check({tag, " stall_out"}, {31'b0, stall_out}, 32'd0);
        check({tag, " clip"}, {29'b0, clip_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s sx%0d", tag, i), sx_out[i], 32'd0);
            check($sformatf("%s sy%0d", tag, i), sy_out[i], 32'd0);
            check($sformatf("%s sz%0d", tag, i), sz_out[i], 32'd0);
        end
    endtask

    vec_t tbl [4];
    vec_t va, vb;

    initial begin
        // Directed vectors with hand-derived expectations.
        tbl[0].done = 1'b0;
        tbl[0] = put(tbl[0], 0, 32'h0, 32'h0, 32'h0, 32'h0001_0000,
                     32'h0140_0000, 32'h00F0_0000, 32'h0000_8000, 1'b0);
        tbl[0] = put(tbl[0], 1, 32'h0002_0000, 32'hFFFE_0000, 32'h0002_0000, 32'h0002_0000,
                     32'h0280_0000, 32'h01E0_0000, 32'h0001_0000, 1'b0);
        tbl[0] = put(tbl[0], 2, 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000,
                     32'h0280_0000, 32'h00F0_0000, 32'h0000_8000, 1'b0);
        tbl[1].done = 1'b1;
        tbl[1] = put(tbl[1], 0, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000,
                     32'h0, 32'h0, 32'h0, 1'b0);
        tbl[1] = put(tbl[1], 1, 32'h0005_0000, 32'h0003_0000, 32'h0001_0000, 32'h0000_8000,
                     32'h0, 32'h0, 32'h0, 1'b1);
        tbl[1] = put(tbl[1], 2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000,
                     32'h0, 32'h0, 32'h0, 1'b1);
        tbl[2].done = 1'b0;
        tbl[2] = put(tbl[2], 0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0,
                     32'h0, 32'h0, 32'h0, 1'b1);
        tbl[2] = put(tbl[2], 1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_FFFF,
                     32'h0, 32'h0, 32'h0, 1'b1);
        tbl[2] = put(tbl[2], 2, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000,
                     32'h01E0_0000, 32'h0078_0000, 32'h0000_C000, 1'b0);
        tbl[3].done = 1'b1;
        tbl[3] = put(tbl[3], 0, 32'h0004_0000, 32'h0004_0000, 32'hFFFC_0000, 32'h0004_0000,
                     32'h0280_0000, 32'h0, 32'h0, 1'b0);
        tbl[3] = put(tbl[3], 1, 32'h0003_0000, 32'h0, 32'h0, 32'h0003_0000,
                     32'h027F_FEC0, 32'h00F0_0000, 32'h0000_8000, 1'b0);
        tbl[3] = put(tbl[3], 2, 32'h4000_0000, 32'h0, 32'h0, 32'h7FFF_FFFF,
                     32'h01E0_0000, 32'h00F0_0000, 32'h0000_8000, 1'b0);

        reset    = 1'b0;
        stall_in = 1'b0;
        scramble();
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Table: back-to-back triangles, done only on the flagged ones.
        for (int t = 0; t < 4; t++) run($sformatf("tbl%0d", t), tbl[t]);

        // Held stall in OUT with the next triangle waiting on the inputs.
        va = rand_vec();
        vb = tbl[0];
        apply(va);
        @(posedge clock);
        #1;
        scramble();
        stall_in = 1'b1;
        wait_out("stallA");
        compare_out("stallA", va);
        apply(vb);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            compare_out($sformatf("stall hold%0d", c), va);
        end
        stall_in = 1'b0;
        @(posedge clock);
        #1;
        check("stall release valid", {31'b0, out_valid}, 32'd0);
        check("stall release stall", {31'b0, stall_out}, 32'd0);
        @(posedge clock);
        #1;
        check("stall reaccept", {31'b0, stall_out}, 32'd1);
        scramble();
        wait_out("stallB");
        compare_out("stallB", vb);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a divide, then a clean triangle.
        apply(tbl[3]);
        @(posedge clock);
        #1;
        scramble();
        repeat (50) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run("after reset", tbl[0]);

        // Random triangles against the model.
        for (int k = 0; k < 8; k++) run($sformatf("rand%0d", k), rand_vec());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vertex_viewport.md
# vertex_viewport

Downstream consumer of the vertex transform stage. Accepts one triangle of three clip-space vertices (x, y, z, w, signed Q16.16) through the valid/stall handshake, performs the perspective divide with a sequential restoring divider, and maps the results to 640×480 screen coordinates plus a [0,1] depth value. Sits between the vertex transform stage and the rasterizer. Holds one triangle at a time.

## Interface
- HALF_W, 32'h0140_0000, half screen width (320.0, Q16.16)
- HALF_H, 32'h00F0_0000, half screen height (240.0, Q16.16)
- clock  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-low
- x_in[3:0], y_in[3:0], z_in[3:0], w_in[3:0]  in  32 each  clip-space vertices; only elements 0..2 are used, element 3 is ignored
- in_valid  in  1  triangle present on the *_in ports
- done_in  in  1  sampled with in_valid; marks the last triangle of the stream
- stall_in  in  1  rasterizer cannot accept the output
- sx_out[2:0], sy_out[2:0], sz_out[2:0]  out  32 each  screen x, screen y, depth (Q16.16)
- clip_out  out  3  bit i set means vertex i has w < 1.0; its sx/sy/sz are 0
- out_valid  out  1  output triangle valid
- done_out  out  1  done flag travelling with the output triangle
- stall_out  out  1  busy; upstream must hold its data

## Operation
- FSM states:
  - IDLE
  - DIV: 33 cycles, one quotient bit per cycle, MSB first
  - MAP: 1 cycle
  - OUT
- State transitions:
  - IDLE → DIV when in_valid; on that edge, latch vertices 0..2 and done_in, and set vertex index v = 0.
  - DIV → MAP when the 6-bit iteration counter reaches 32.
  - MAP → DIV (v+1) if v < 2; otherwise MAP → OUT.
  - OUT → IDLE on the first edge with stall_in = 0.
- Reciprocal: r = floor(2^32 / w) as unsigned 33-bit restoring division. The division only runs meaningfully for w ≥ 32'h0001_0000, which gives r ≤ 32'h0001_0000.
- Clip condition: w < 32'h0001_0000, signed compare, covering zero and negative w.
  - The divider still runs the full 33 cycles, so latency stays fixed.
  - Results are forced to 0 and clip bit v is set.
- fmul(a, b): signed 32×32 → 64-bit product, arithmetic shift right by 16, keep the low 32 bits. Wraps on overflow; no saturation.
- Computations in MAP, for vertex v:
  - nx = fmul(x, r), ny = fmul(y, r), nz = fmul(z, r)
  - sx = HALF_W + fmul(nx, HALF_W)
  - sy = HALF_H − fmul(ny, HALF_H) (Y flipped so that +1.0 maps to row 0)
  - sz = 32'h0000_8000 + (nz >>> 1)
- Results are written into output registers at index v.
- in_valid is ignored outside IDLE.
- stall_in is ignored outside OUT.
- done_in is only sampled on the accepting edge.

## Timing
- Reset values:
  - state IDLE
  - all sx/sy/sz 0, clip_out 0
  - out_valid 0, done_out 0, stall_out 0
- stall_out is a Moore output: 1 in every state except IDLE. It rises on the edge after acceptance.
- Latency: out_valid rises exactly 102 edges after the accepting edge (3 × (33 + 1)).
- out_valid, done_out, sx/sy/sz and clip_out stay stable throughout OUT.
- On leaving OUT:
  - out_valid and done_out drop on the releasing edge.
  - stall_out drops on the same edge.
- Throughput: the next triangle can be accepted no earlier than 1 cycle after release, so at most 1 triangle per 104 cycles.
- Reset asserted mid-operation immediately (asynchronously) returns the block to IDLE with the reset values; any partial triangle is discarded.

## Structure
- Shared package vp_pkg holds:
  - the Q16.16 type and the fmul function
  - the ONE constant (32'h0001_0000) and HALF (32'h0000_8000)
  - the state enum
- Sub-module recip_div: sequential unsigned 2^32 / d.
  - Ports: start, d[31:0], busy, done, q[32:0].
  - Fixed 33-cycle latency.
  - Owns the iteration counter and remainder.
- Top level holds the FSM, the vertex latch, the mapping arithmetic and the output registers.

## Test plan
- Vertex 0 at x=y=z=0, w=1.0 → sx 32'h0140_0000, sy 32'h00F0_0000, sz 32'h0000_8000, clip 0. out_valid rises exactly 102 cycles after acceptance.
- x=2.0, y=−2.0, z=2.0, w=2.0 (r = 32'h0000_8000) → sx 32'h0280_0000, sy 32'h01E0_0000, sz 32'h0001_0000.
- Vertex 1 with w = 32'h0000_8000 and vertex 2 with w = 32'hFFFF_0000 → clip_out 3'b110, their outputs 0. Vertex 0 is unaffected and latency is unchanged.
- stall_in held for 10 cycles while in OUT, with in_valid = 1 throughout:
  - outputs and out_valid stay frozen and stall_out stays 1
  - a new triangle is accepted 1 cycle after release
- done_in = 1 on the second of two triangles → done_out = 1 only with the second out_valid.
- reset pulsed low at cycle 50 during DIV → all outputs return to reset values within the same cycle. A following triangle produces correct results with the full 102-cycle latency.
